mem_arbiter: RTL and testbench

Two-port round-robin arbiter and sequencer for the single-ported 128×32 instruction/data memory. It shares the memory's CS/WE/ADDR/Mem_Bus interface between the MIPS CPU (port 0) and a second bus master (port 1, a loader/debug DMA). It sits between the requesters and the memory and owns the tri-state data bus. Each granted access is a fixed three-cycle transaction with a one-cycle acknowledge.

---
 rtl/mem_arbiter.sv | 87 ++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-ported memory.
// Each grant runs IDLE -> ACCESS -> RESP with a one-cycle ack in RESP.
module mem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic              last_gnt;
    logic              own;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              pick;

    // On a tie the port opposite the previous winner gets the grant.
    always_comb begin
        pick = (req0 && req1) ? ~last_gnt : req1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            own       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        own       <= pick;
                        last_gnt  <= pick;
                        lat_we    <= pick ? we1 : we0;
                        lat_addr  <= pick ? addr1 : addr0;
                        lat_wdata <= pick ? wdata1 : wdata0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Memory has driven the bus since the mid-cycle negedge.
                    if (!lat_we) rdata <= Mem_Bus;
                    state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ACCESS) || (state == RESP);
    assign CS   = (state == ACCESS);
    assign WE   = CS && lat_we;
    assign ADDR = CS ? lat_addr : '0;
    assign gnt  = busy ? (own ? 2'b10 : 2'b01) : 2'b00;
    assign ack0 = (state == RESP) && !own;
    assign ack1 = (state == RESP) && own;

    assign Mem_Bus = (CS && lat_we) ? lat_wdata : 'z;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions with an expected-ack
// queue drained by a monitor, plus a small RAM model on the shared bus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [6:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, CS, WE;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    logic [6:0]  ADDR;
    wire  [31:0] mem_bus;

    mem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .gnt(gnt), .busy(busy),
        .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(mem_bus)
    );

    always #5 clk = ~clk;

    // RAM model: acts on the negedge inside the access cycle.
    logic [31:0] ram [128];
    logic [31:0] rd_q = '0;
    logic        pl_en = 1'b0;
    logic [6:0]  pl_addr = '0;
    logic [31:0] pl_data = '0;

    always @(negedge clk) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (CS) begin
            if (WE) ram[ADDR] <= mem_bus;
            else    rd_q <= ram[ADDR];
        end
    end
    assign mem_bus = (CS && !WE) ? rd_q : 'z;

    typedef struct packed {
        logic        port;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_total = 0;
    int   n_pass  = 0;
    int   cs_cycles;
    logic [6:0]  seen_addr;
    logic [31:0] seen_bus;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(negedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic push(input logic p, input logic rd, input logic [31:0] d);
        exp_t x;
        x.port = p;
        x.rd   = rd;
        x.data = d;
        sb.push_back(x);
    endtask

    // Issue one request and hold it until its ack, then drop it.
    task automatic txn(input logic p, input logic w, input logic [6:0] a,
                       input logic [31:0] d, input logic [31:0] e);
        logic got;
        push(p, !w, e);
        if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        cs_cycles = 0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick();
            if (CS) begin
                cs_cycles++;
                seen_addr = ADDR;
                if (WE) seen_bus = mem_bus;
            end
            if (p ? ack1 : ack0) got = 1'b1;
        end
        chk("ack_arrived", 32'(got), 32'd1);
        if (!p) req0 = 1'b0;
        else    req1 = 1'b0;
        tick();
    endtask

    // Monitor: every ack is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (ack0 || ack1)) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", 32'({ack1, ack0}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_port", 32'({ack1, ack0}), mon_e.port ? 32'd2 : 32'd1);
                if (mon_e.rd) chk("rdata", rdata, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctl", 32'({ack0, ack1, busy, CS, WE, gnt}), 32'd0);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single read on port 0
        preload(7'd5, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 7'd5, 32'd0, 32'hDEADBEEF);
        chk("rd_cs_cycles", 32'(cs_cycles), 32'd1);
        chk("rd_addr", 32'(seen_addr), 32'd5);

        // Port 1 write then read of the top address
        txn(1'b1, 1'b1, 7'h7f, 32'h12345678, 32'd0);
        chk("wr_bus", seen_bus, 32'h12345678);
        chk("wr_ram", ram[127], 32'h12345678);
        txn(1'b1, 1'b0, 7'h7f, 32'd0, 32'h12345678);
        chk("rd_top_addr", 32'(seen_addr), 32'h7f);

        // Address change after grant is ignored
        preload(7'd3, 32'h33333333);
        preload(7'd9, 32'h99999999);
        push(1'b0, 1'b1, 32'h33333333);
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'd3;
        tick();
        addr0 = 7'd9;
        chk("lat_addr", 32'(ADDR), 32'd3);
        chk("lat_cs", 32'(CS), 32'd1);
        tick();
        chk("lat_ack", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick();

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ctl", 32'({CS, WE, busy, ack0, ack1, gnt}), 32'd0);
            chk("idle_rdata", rdata, 32'h33333333);
        end

        // Contention from reset: strict alternation 0,1,0,1
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        preload(7'd10, 32'hA0A0A0A0);
        preload(7'd11, 32'hB1B1B1B1);
        push(1'b0, 1'b1, 32'hA0A0A0A0);
        push(1'b1, 1'b1, 32'hB1B1B1B1);
        push(1'b0, 1'b1, 32'hA0A0A0A0);
        push(1'b1, 1'b1, 32'hB1B1B1B1);
        req0 = 1'b1; we0 = 1'b0; addr0 = 7'd10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 7'd11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cont_gnt_acc", 32'(gnt), (i % 2) ? 32'd2 : 32'd1);
            chk("cont_cs", 32'(CS), 32'd1);
            tick();
            chk("cont_gnt_resp", 32'(gnt), (i % 2) ? 32'd2 : 32'd1);
            chk("cont_ack", 32'({ack1, ack0}), (i % 2) ? 32'd2 : 32'd1);
            if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            chk("cont_gnt_idle", 32'(gnt), 32'd0);
        end
        tick();
        chk("cont_done", 32'({busy, CS}), 32'd0);
        chk("cont_rdata", rdata, 32'hB1B1B1B1);

        // Reset in the middle of a port 0 write
        req0 = 1'b1; we0 = 1'b1; addr0 = 7'd20; wdata0 = 32'hCAFEF00D;
        tick();
        chk("mid_cs_we", 32'({CS, WE, busy}), 32'd7);
        chk("mid_bus", mem_bus, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'({CS, WE, busy, ack0, ack1, gnt}), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        req0 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_idle", 32'({CS, busy, ack0, ack1}), 32'd0);
        end

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
